// File: rtl/spiker_stream_adapter.sv
// Streams a padded spike-vector snapshot to the spiker core and gathers the result words back.
// Latency: done_o at start+1+N_WORDS (loopback) or start+1+2*N_WORDS (core always ready/valid).
// Backpressure: outbound beat holds while core_ready_i is low; inbound accepted only in RECV.
module spiker_stream_adapter #(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        test_mode_i,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic [((N_SPIKES+WIDTH-1)/WIDTH)*WIDTH-1:0] spikes_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        result_valid_o,
    output logic [((N_SPIKES+WIDTH-1)/WIDTH)*WIDTH-1:0] result_o,
    output logic                        core_valid_o,
    input  logic                        core_ready_i,
    output logic [WIDTH-1:0]            core_data_o,
    output logic                        core_last_o,
    input  logic                        core_res_valid_i,
    input  logic [WIDTH-1:0]            core_res_data_i,
    output logic                        core_res_ready_o
);

    localparam int N_WORDS   = (N_SPIKES + WIDTH - 1) / WIDTH;
    localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TAIL_BITS = N_SPIKES - (N_WORDS - 1) * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Valid-bit mask for the final word; all ones when the spike count fills it exactly.
    function automatic logic [WIDTH-1:0] tail_mask();
        logic [WIDTH-1:0] m;
        for (int b = 0; b < WIDTH; b++) begin
            m[b] = (b < TAIL_BITS);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAIL_MASK = tail_mask();

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             loop_mode;
    logic             done_q;
    logic             res_vld_q;
    logic [WIDTH-1:0] snap [N_WORDS];
    logic [WIDTH-1:0] res  [N_WORDS];
    logic             is_last;
    logic [WIDTH-1:0] word_mask;

    assign is_last   = (idx == LAST_IDX);
    assign word_mask = is_last ? TAIL_MASK : {WIDTH{1'b1}};

    assign busy_o           = (state != S_IDLE);
    assign done_o           = done_q;
    assign result_valid_o   = res_vld_q;
    assign core_valid_o     = (state == S_SEND) && !loop_mode;
    assign core_data_o      = core_valid_o ? snap[idx] : '0;
    assign core_last_o      = core_valid_o && is_last;
    assign core_res_ready_o = (state == S_RECV);

    for (genvar k = 0; k < N_WORDS; k++) begin : g_result
        assign result_o[k*WIDTH +: WIDTH] = res[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            idx       <= '0;
            loop_mode <= 1'b0;
            done_q    <= 1'b0;
            res_vld_q <= 1'b0;
            for (int k = 0; k < N_WORDS; k++) begin
                snap[k] <= '0;
                res[k]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            // Abort drops any in-flight beat but keeps the last stored result words.
            if (clear_i) begin
                state     <= S_IDLE;
                idx       <= '0;
                res_vld_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            for (int k = 0; k < N_WORDS; k++) begin
                                snap[k] <= spikes_i[k*WIDTH +: WIDTH] &
                                           ((k == N_WORDS - 1) ? TAIL_MASK : {WIDTH{1'b1}});
                            end
                            loop_mode <= test_mode_i;
                            res_vld_q <= 1'b0;
                            idx       <= '0;
                            state     <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (loop_mode) begin
                            res[idx] <= snap[idx];
                            if (is_last) begin
                                idx       <= '0;
                                state     <= S_DONE;
                                done_q    <= 1'b1;
                                res_vld_q <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (core_ready_i) begin
                            if (is_last) begin
                                idx   <= '0;
                                state <= S_RECV;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    S_RECV: begin
                        if (core_res_valid_i) begin
                            res[idx] <= core_res_data_i & word_mask;
                            if (is_last) begin
                                idx       <= '0;
                                state     <= S_DONE;
                                done_q    <= 1'b1;
                                res_vld_q <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
